div_share_sched: RTL and testbench
==================================

Name: div_share_sched

Overview:
- Sequencing controller that shares one combinational 16/8 array divider instance (exact or approximate subtractor-cell variant) among NUM_REQ requesters.
- Arbitrates requests round-robin and registers the operands onto the shared divider.
- Waits a programmable multicycle settle time, then captures the quotient and remainder into a response register with a valid/ready handshake.
- Detects divide-by-zero and quotient overflow and resolves them without using the divider.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LAT, 3, settle cycles allowed for the combinational divider path (1..15).
- IDW, 2, width of the requester index; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_n  in  16*NUM_REQ  dividends; requester i occupies bits [16i+15:16i].
- req_d  in  8*NUM_REQ  divisors; requester i occupies bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot grant/accept strobe.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  IDW  index of the requester being answered.
- rsp_q  out  8  quotient.
- rsp_r  out  8  remainder.
- rsp_dz  out  1  divide-by-zero flag.
- rsp_ovf  out  1  quotient-overflow flag.
- div_n  out  16  registered dividend to the shared divider.
- div_d  out  8  registered divisor to the shared divider.
- div_q  in  8  quotient from the shared divider.
- div_r  in  8  remainder from the shared divider.
- busy  out  1  high whenever state is not IDLE.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE.
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_q=0, rsp_r=0, rsp_dz=0, rsp_ovf=0, div_n=0, div_d=0, busy=0, wait counter=0.
  - RR pointer=NUM_REQ-1, so requester 0 has highest priority first.
  - Reset mid-operation aborts the operation; no response is produced for it.
- States: IDLE, WAIT, RESP.
- IDLE:
  - If any req_valid, pick the first valid index scanning from ptr+1 upward, modulo NUM_REQ.
  - req_ready[g]=1 combinationally in that same cycle (one-hot, only in IDLE); the transfer occurs that cycle.
  - On transfer:
    - ptr<=g, rsp_id<=g.
    - Classify: dz = (d==0); ovf = !dz && (n[15:8] >= d).
    - If dz: rsp_q<=8'hFF, rsp_r<=n[7:0], rsp_dz<=1, rsp_ovf<=0, go RESP; div_n/div_d unchanged.
    - Else if ovf: rsp_q<=8'hFF, rsp_r<=8'hFF, rsp_ovf<=1, rsp_dz<=0, go RESP; div_n/div_d unchanged.
    - Else: div_n<=n, div_d<=d, counter<=LAT-1, go WAIT.
- WAIT:
  - div_n/div_d held stable.
  - If counter==0: rsp_q<=div_q, rsp_r<=div_r, rsp_dz<=0, rsp_ovf<=0, go RESP.
  - Else counter decrements.
- RESP:
  - rsp_valid=1 (registered; equivalently state==RESP). rsp_* fields stay stable while rsp_valid=1 && rsp_ready=0.
  - On rsp_ready=1: go IDLE. The next grant is no earlier than the following cycle (no grant in the RESP cycle).
- Latency, with the transfer in cycle T:
  - Normal requests: rsp_valid first high in cycle T+LAT+1.
  - dz/ovf requests: rsp_valid high in cycle T+1.
- Throughput: one operation at a time; minimum spacing between grants is LAT+2 cycles (normal) or 2 cycles (dz/ovf).
- Requests not granted are not latched; requesters must hold req_valid and operands until req_ready.
- A req_valid deassert or operand change after its transfer has no effect on the operation in flight.
- div_n/div_d never change outside a normal-request transfer, which avoids needless toggling of the divider array.
- Overflow comparison is unsigned, 8-bit vs 8-bit.
- The approximate divider result is passed through unmodified; no correction.

Test Plan:
- Reset then single request on port 1: n=16'd200, d=8'd7, LAT=3, divider model exact -> req_ready[1] in the valid cycle T; rsp_valid at T+4 with rsp_id=1, q=28, r=4, dz=0, ovf=0.
- Divide by zero: port 0 n=16'h1234, d=0 -> rsp_valid at T+1 with q=8'hFF, r=8'h34, dz=1; div_n/div_d remain at their previous values.
- Overflow: n=16'h0A00, d=8'h05 -> rsp at T+1 with q=8'hFF, r=8'hFF, ovf=1. Boundary case n=16'h04FF, d=5 -> normal path, q=255, r=4.
- All four ports valid continuously after reset -> grant order 0,1,2,3,0.
  - Each rsp_id matches its grant; no port is granted twice before the others are served.
- Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp fields and rsp_valid stable, no req_ready asserted; rsp_ready=1 -> IDLE next cycle, new grant the cycle after.
- rst_n=0 asserted during WAIT -> all outputs return to reset values next edge, no response for the aborted request, and port 0 regains first priority.

Source files
------------

// File: rtl/div_share_sched.sv
// div_share_sched
//   Shares one combinational 16/8 array divider between NUM_REQ requesters.
//   A round-robin arbiter grants one request at a time. Divide-by-zero and
//   quotient-overflow cases are resolved locally without touching the divider.
//   Normal operands are registered onto the divider, given LAT settle cycles,
//   and then the result is captured into a valid/ready response register.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   req_valid/req_n/req_d per-requester request valid, dividend, divisor
//   req_ready             one-hot grant, asserted only in IDLE
//   rsp_*                 response handshake, requester id, q/r, dz/ovf flags
//   div_n/div_d           registered operands to the shared divider
//   div_q/div_r           divider result
//   busy                  high when the controller is not IDLE
//
// state | meaning
// IDLE  | arbitrate; accept one request
// WAIT  | divider operands stable, counting down the settle time
// RESP  | response valid, waiting for rsp_ready
module div_share_sched #(
  parameter int NUM_REQ = 4,
  parameter int LAT     = 3,
  parameter int IDW     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [16*NUM_REQ-1:0]  req_n,
  input  logic [8*NUM_REQ-1:0]   req_d,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [7:0]             rsp_q,
  output logic [7:0]             rsp_r,
  output logic                   rsp_dz,
  output logic                   rsp_ovf,
  output logic [15:0]            div_n,
  output logic [7:0]             div_d,
  input  logic [7:0]             div_q,
  input  logic [7:0]             div_r,
  output logic                   busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  logic [7:0]     rsp_q_q, rsp_q_d;
  logic [7:0]     rsp_r_q, rsp_r_d;
  logic           rsp_dz_q, rsp_dz_d;
  logic           rsp_ovf_q, rsp_ovf_d;
  logic [15:0]    div_n_q, div_n_d;
  logic [7:0]     div_d_q, div_d_d;

  logic           gnt_any;
  logic [IDW-1:0] gnt_idx;
  logic [IDW-1:0] scan_idx;
  logic [15:0]    sel_n;
  logic [7:0]     sel_d;
  logic           sel_dz;
  logic           sel_ovf;

  // Round-robin pick: scan from ptr+1 upward. Iterating from the farthest
  // candidate down lets the nearest valid one overwrite earlier picks.
  always_comb begin
    gnt_any  = |req_valid;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      scan_idx = IDW'((int'(ptr_q) + k) % NUM_REQ);
      if (req_valid[scan_idx]) gnt_idx = scan_idx;
    end
  end

  always_comb begin
    sel_n     = '0;
    sel_d     = '0;
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == IDW'(i)) begin
        sel_n = req_n[16*i +: 16];
        sel_d = req_d[8*i +: 8];
      end
      req_ready[i] = (state_q == IDLE) && gnt_any && (gnt_idx == IDW'(i));
    end
    sel_dz  = (sel_d == 8'd0);
    // Quotient fits in 8 bits only if the dividend's upper byte is below d.
    sel_ovf = !sel_dz && (sel_n[15:8] >= sel_d);
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    rsp_id_d  = rsp_id_q;
    rsp_q_d   = rsp_q_q;
    rsp_r_d   = rsp_r_q;
    rsp_dz_d  = rsp_dz_q;
    rsp_ovf_d = rsp_ovf_q;
    div_n_d   = div_n_q;
    div_d_d   = div_d_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_any) begin
          ptr_d    = gnt_idx;
          rsp_id_d = gnt_idx;
          if (sel_dz) begin
            rsp_q_d   = 8'hFF;
            rsp_r_d   = sel_n[7:0];
            rsp_dz_d  = 1'b1;
            rsp_ovf_d = 1'b0;
            state_d   = RESP;
          end else if (sel_ovf) begin
            rsp_q_d   = 8'hFF;
            rsp_r_d   = 8'hFF;
            rsp_dz_d  = 1'b0;
            rsp_ovf_d = 1'b1;
            state_d   = RESP;
          end else begin
            div_n_d = sel_n;
            div_d_d = sel_d;
            cnt_d   = 4'(LAT - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_q_d   = div_q;
          rsp_r_d   = div_r;
          rsp_dz_d  = 1'b0;
          rsp_ovf_d = 1'b0;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= IDW'(NUM_REQ - 1);
      cnt_q     <= '0;
      rsp_id_q  <= '0;
      rsp_q_q   <= '0;
      rsp_r_q   <= '0;
      rsp_dz_q  <= 1'b0;
      rsp_ovf_q <= 1'b0;
      div_n_q   <= '0;
      div_d_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      rsp_id_q  <= rsp_id_d;
      rsp_q_q   <= rsp_q_d;
      rsp_r_q   <= rsp_r_d;
      rsp_dz_q  <= rsp_dz_d;
      rsp_ovf_q <= rsp_ovf_d;
      div_n_q   <= div_n_d;
      div_d_q   <= div_d_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_q     = rsp_q_q;
  assign rsp_r     = rsp_r_q;
  assign rsp_dz    = rsp_dz_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign div_n     = div_n_q;
  assign div_d     = div_d_q;

endmodule

// File: tb/tb_div_share_sched.sv
module tb_div_share_sched;
  localparam int NUM_REQ = 4;
  localparam int LAT     = 3;
  localparam int IDW     = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_n;
  logic [8*NUM_REQ-1:0]  req_d;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [7:0]            rsp_q;
  logic [7:0]            rsp_r;
  logic                  rsp_dz;
  logic                  rsp_ovf;
  logic [15:0]           div_n;
  logic [7:0]            div_d;
  logic [7:0]            div_q;
  logic [7:0]            div_r;
  logic                  busy;

  div_share_sched #(.NUM_REQ(NUM_REQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_n(req_n), .req_d(req_d), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_q(rsp_q), .rsp_r(rsp_r), .rsp_dz(rsp_dz), .rsp_ovf(rsp_ovf),
    .div_n(div_n), .div_d(div_d), .div_q(div_q), .div_r(div_r), .busy(busy)
  );

  always #5 clk = ~clk;

  // exact shared divider
  assign div_q = (div_d == 8'd0) ? 8'd0 : 8'(div_n / 16'(div_d));
  assign div_r = (div_d == 8'd0) ? 8'd0 : 8'(div_n % 16'(div_d));

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [7:0]     q;
    logic [7:0]     r;
    logic           dz;
    logic           ovf;
  } exp_t;

  exp_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_id",  32'(rsp_id),  32'(e.id));
        chk("rsp_q",   32'(rsp_q),   32'(e.q));
        chk("rsp_r",   32'(rsp_r),   32'(e.r));
        chk("rsp_dz",  32'(rsp_dz),  32'(e.dz));
        chk("rsp_ovf", 32'(rsp_ovf), 32'(e.ovf));
      end
    end
  end

  function automatic exp_t mk(input int id, input int q, input int r, input bit dz, input bit ovf);
    exp_t e;
    e.id = IDW'(id); e.q = 8'(q); e.r = 8'(r); e.dz = dz; e.ovf = ovf;
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_id"},    32'(rsp_id),    32'd0);
    chk({tag, "_rsp_q"},     32'(rsp_q),     32'd0);
    chk({tag, "_rsp_r"},     32'(rsp_r),     32'd0);
    chk({tag, "_rsp_flags"}, 32'({rsp_dz, rsp_ovf}), 32'd0);
    chk({tag, "_div_n"},     32'(div_n),     32'd0);
    chk({tag, "_div_d"},     32'(div_d),     32'd0);
    chk({tag, "_busy"},      32'(busy),      32'd0);
  endtask

  task automatic set_op(input int port, input int n, input int d);
    req_n[16*port +: 16] = 16'(n);
    req_d[8*port +: 8]   = 8'(d);
  endtask

  // Called at posedge+1 with the DUT in IDLE; returns at posedge+1 after transfer.
  task automatic issue(input int port, input int n, input int d, input exp_t e, input bit push);
    set_op(port, n, d);
    req_valid = NUM_REQ'(1) << port;
    @(negedge clk);
    chk("grant", 32'(req_ready), 32'(NUM_REQ'(1) << port));
    if (push) exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid = '0;
  endtask

  task automatic wait_rsp(input int exp_lat, input string name, input bit adv);
    int lat = 0;
    bit seen = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        seen = 1;
        lat = i;
      end
    end
    chk(name, 32'(lat), 32'(exp_lat));
    if (adv) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int grants;
    int last_cyc;
    int cyc;
    int exp_port;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_n = '0;
    req_d = '0;
    @(posedge clk); #1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // normal request on port 1: 200/7
    issue(1, 200, 7, mk(1, 28, 4, 0, 0), 1);
    chk("norm_div_n", 32'(div_n), 32'd200);
    wait_rsp(LAT + 1, "norm_lat", 1);

    // divide by zero on port 0
    issue(0, 16'h1234, 0, mk(0, 8'hFF, 8'h34, 1, 0), 1);
    wait_rsp(1, "dz_lat", 1);
    chk("dz_div_n_held", 32'(div_n), 32'd200);
    chk("dz_div_d_held", 32'(div_d), 32'd7);

    // overflow on port 2, then boundary just below overflow on port 3
    issue(2, 16'h0A00, 5, mk(2, 8'hFF, 8'hFF, 0, 1), 1);
    wait_rsp(1, "ovf_lat", 1);
    chk("ovf_div_n_held", 32'(div_n), 32'd200);
    issue(3, 16'h04FF, 5, mk(3, 255, 4, 0, 0), 1);
    wait_rsp(LAT + 1, "bound_lat", 1);
    chk("bound_div_n", 32'(div_n), 32'h04FF);

    // all four ports continuously valid from reset
    do_reset();
    for (int p = 0; p < NUM_REQ; p++) set_op(p, 100 + 10 * p, 3 + p);
    req_valid = '1;
    grants = 0;
    last_cyc = 0;
    cyc = 0;
    for (int i = 0; i < 200 && grants < 5; i++) begin
      @(negedge clk);
      cyc++;
      if (req_ready != '0) begin
        exp_port = grants % NUM_REQ;
        chk("rr_grant", 32'(req_ready), 32'(NUM_REQ'(1) << exp_port));
        if (grants > 0) chk("rr_spacing", 32'(cyc - last_cyc), 32'(LAT + 2));
        case (exp_port)
          0: exp_q.push_back(mk(0, 33, 1, 0, 0));
          1: exp_q.push_back(mk(1, 27, 2, 0, 0));
          2: exp_q.push_back(mk(2, 24, 0, 0, 0));
          default: exp_q.push_back(mk(3, 21, 4, 0, 0));
        endcase
        last_cyc = cyc;
        grants++;
      end
    end
    chk("rr_grant_count", 32'(grants), 32'd5);
    @(posedge clk); #1;
    req_valid = '0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    chk("rr_drain", 32'(exp_q.size()), 32'd0);
    @(posedge clk); #1;

    // backpressure on port 1 (50/7) with port 2 waiting (90/9)
    rsp_ready = 1'b0;
    issue(1, 50, 7, mk(1, 7, 1, 0, 0), 1);
    wait_rsp(LAT + 1, "bp_lat", 0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (i == 0) begin
        set_op(2, 90, 9);
        req_valid = 4'b0100;
      end
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_fields", 32'({rsp_id, rsp_q, rsp_r, rsp_dz, rsp_ovf}),
          32'({2'd1, 8'd7, 8'd1, 1'b0, 1'b0}));
      chk("bp_no_grant", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'b0100);
    exp_q.push_back(mk(2, 10, 0, 0, 0));
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(LAT + 1, "bp_next_lat", 1);

    // reset during WAIT aborts port 0 operation and restores priority
    issue(0, 300, 10, mk(0, 30, 0, 0, 0), 0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("abort");
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk); #1;
    set_op(0, 77, 8);
    set_op(1, 40, 4);
    req_valid = 4'b0011;
    @(negedge clk);
    chk("abort_prio", 32'(req_ready), 32'b0001);
    exp_q.push_back(mk(0, 9, 5, 0, 0));
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(LAT + 1, "abort_next_lat", 1);

    @(negedge clk);
    chk("final_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
